// File: rtl/secded_pipe_decoder.sv
// Two-stage extended-Hamming SECDED decoder with a valid/ready stream interface,
// an optional detect-only mode and saturating SEC/DED statistics counters.
module secded_pipe_decoder #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16,
    localparam int P  = (DATA_W <= 1)  ? 2 :
                        (DATA_W <= 4)  ? 3 :
                        (DATA_W <= 11) ? 4 :
                        (DATA_W <= 26) ? 5 :
                        (DATA_W <= 57) ? 6 : 7,
    localparam int CW = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_code,
    input  logic              cfg_correct,
    input  logic              cnt_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     out_code,
    output logic              out_sec,
    output logic              out_ded,
    output logic [CNT_W-1:0]  cnt_sec,
    output logic [CNT_W-1:0]  cnt_ded
);
    localparam logic [P-1:0]     MAX_POS = P'(CW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              s1_v_q, s1_v_d;
    logic [CW-1:0]     s1_code_q, s1_code_d;
    logic [P-1:0]      s1_syn_q, s1_syn_d;
    logic              s1_g_q, s1_g_d;
    logic              s1_corr_q, s1_corr_d;

    logic              s2_v_q, s2_v_d;
    logic [CW-1:0]     s2_code_q, s2_code_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic              s2_sec_q, s2_sec_d;
    logic              s2_ded_q, s2_ded_d;

    logic [CNT_W-1:0]  cnt_sec_q, cnt_sec_d;
    logic [CNT_W-1:0]  cnt_ded_q, cnt_ded_d;

    logic              s2_load, s1_load, out_xfer;
    logic [P-1:0]      in_syn;
    logic              in_g;
    logic              st_sec, st_ded;
    logic [CW-1:0]     fixed_code;
    logic [DATA_W-1:0] fixed_data;
    int                dj;

    always_comb begin
        s2_load  = !s2_v_q || out_ready;
        s1_load  = !s1_v_q || s2_load;
        in_ready = s1_load;
        out_xfer = s2_v_q && out_ready;
    end

    always_comb begin
        in_syn = '0;
        for (int i = 1; i < CW; i++) begin
            if (in_code[i]) begin
                in_syn ^= P'(i);
            end
        end
        in_g = ^in_code;
    end

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_code_d = s1_code_q;
        s1_syn_d  = s1_syn_q;
        s1_g_d    = s1_g_q;
        s1_corr_d = s1_corr_q;
        if (s1_load) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_code_d = in_code;
                s1_syn_d  = in_syn;
                s1_g_d    = in_g;
                s1_corr_d = cfg_correct;
            end
        end
    end

    // A zero syndrome with odd overall parity points at bit 0, so the
    // syndrome value doubles as the flip position for every SEC case.
    always_comb begin
        st_sec = s1_g_q && (s1_syn_q <= MAX_POS);
        st_ded = (s1_syn_q != '0) && !st_sec;
        for (int i = 0; i < CW; i++) begin
            fixed_code[i] = s1_code_q[i] ^ (st_sec && s1_corr_q && (s1_syn_q == P'(i)));
        end
        fixed_data = '0;
        dj = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                fixed_data[dj] = fixed_code[pos];
                dj++;
            end
        end
    end

    always_comb begin
        s2_v_d    = s2_v_q;
        s2_code_d = s2_code_q;
        s2_data_d = s2_data_q;
        s2_sec_d  = s2_sec_q;
        s2_ded_d  = s2_ded_q;
        if (s2_load) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_code_d = fixed_code;
                s2_data_d = fixed_data;
                s2_sec_d  = st_sec;
                s2_ded_d  = st_ded;
            end
        end
    end

    always_comb begin
        cnt_sec_d = cnt_sec_q;
        cnt_ded_d = cnt_ded_q;
        if (cnt_clear) begin
            cnt_sec_d = '0;
            cnt_ded_d = '0;
        end else begin
            if (out_xfer && s2_sec_q && (cnt_sec_q != CNT_MAX)) begin
                cnt_sec_d = cnt_sec_q + CNT_W'(1);
            end
            if (out_xfer && s2_ded_q && (cnt_ded_q != CNT_MAX)) begin
                cnt_ded_d = cnt_ded_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_v_q    <= 1'b0;
            s1_code_q <= '0;
            s1_syn_q  <= '0;
            s1_g_q    <= 1'b0;
            s1_corr_q <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_code_q <= '0;
            s2_data_q <= '0;
            s2_sec_q  <= 1'b0;
            s2_ded_q  <= 1'b0;
            cnt_sec_q <= '0;
            cnt_ded_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_code_q <= s1_code_d;
            s1_syn_q  <= s1_syn_d;
            s1_g_q    <= s1_g_d;
            s1_corr_q <= s1_corr_d;
            s2_v_q    <= s2_v_d;
            s2_code_q <= s2_code_d;
            s2_data_q <= s2_data_d;
            s2_sec_q  <= s2_sec_d;
            s2_ded_q  <= s2_ded_d;
            cnt_sec_q <= cnt_sec_d;
            cnt_ded_q <= cnt_ded_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_code  = s2_code_q;
    assign out_data  = s2_data_q;
    assign out_sec   = s2_sec_q;
    assign out_ded   = s2_ded_q;
    assign cnt_sec   = cnt_sec_q;
    assign cnt_ded   = cnt_ded_q;

endmodule

// File: tb/tb_secded_pipe_decoder.sv
// Self-checking bench for secded_pipe_decoder: directed words, a randomized stalled
// stream against an encode-and-inject reference model, reset, saturation, wide widths.
module tb_secded_pipe_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Main instance: DATA_W=4, CNT_W=16
    logic        a_in_valid, a_in_ready, a_cfg, a_clr, a_out_valid, a_out_ready, a_sec, a_ded;
    logic [7:0]  a_in_code, a_out_code;
    logic [3:0]  a_out_data;
    logic [15:0] a_cnt_sec, a_cnt_ded;

    // Saturation instance: DATA_W=4, CNT_W=2
    logic        s_in_valid, s_in_ready, s_cfg, s_clr, s_out_valid, s_out_ready, s_sec, s_ded;
    logic [7:0]  s_in_code, s_out_code;
    logic [3:0]  s_out_data;
    logic [1:0]  s_cnt_sec, s_cnt_ded;

    // DATA_W=8 (CW=13)
    logic        b_in_valid, b_in_ready, b_cfg, b_clr, b_out_valid, b_out_ready, b_sec, b_ded;
    logic [12:0] b_in_code, b_out_code;
    logic [7:0]  b_out_data;
    logic [15:0] b_cnt_sec, b_cnt_ded;

    // DATA_W=32 (CW=39)
    logic        c_in_valid, c_in_ready, c_cfg, c_clr, c_out_valid, c_out_ready, c_sec, c_ded;
    logic [38:0] c_in_code, c_out_code;
    logic [31:0] c_out_data;
    logic [15:0] c_cnt_sec, c_cnt_ded;

    secded_pipe_decoder #(.DATA_W(4), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_code(a_in_code), .cfg_correct(a_cfg), .cnt_clear(a_clr),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_code(a_out_code), .out_sec(a_sec), .out_ded(a_ded),
        .cnt_sec(a_cnt_sec), .cnt_ded(a_cnt_ded));

    secded_pipe_decoder #(.DATA_W(4), .CNT_W(2)) u_s (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_code(s_in_code), .cfg_correct(s_cfg), .cnt_clear(s_clr),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_code(s_out_code), .out_sec(s_sec), .out_ded(s_ded),
        .cnt_sec(s_cnt_sec), .cnt_ded(s_cnt_ded));

    secded_pipe_decoder #(.DATA_W(8), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_code(b_in_code), .cfg_correct(b_cfg), .cnt_clear(b_clr),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_code(b_out_code), .out_sec(b_sec), .out_ded(b_ded),
        .cnt_sec(b_cnt_sec), .cnt_ded(b_cnt_ded));

    secded_pipe_decoder #(.DATA_W(32), .CNT_W(16)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_code(c_in_code), .cfg_correct(c_cfg), .cnt_clear(c_clr),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_code(c_out_code), .out_sec(c_sec), .out_ded(c_ded),
        .cnt_sec(c_cnt_sec), .cnt_ded(c_cnt_ded));

    typedef struct {
        logic [7:0] code;
        logic [3:0] data;
        logic       sec;
        logic       ded;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    exp_t got;

    function automatic int calc_p(input int dw);
        int p = 1;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    // Reference encoder: place data at non-power-of-two positions, set each check
    // bit to make its parity group even, then make the whole word even via bit 0.
    function automatic logic [127:0] encode(input logic [63:0] d, input int dw);
        int p = calc_p(dw);
        int cw = dw + p + 1;
        int j = 0;
        int s = 0;
        logic [127:0] c = '0;
        for (int pos = 1; pos < cw; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[j];
                if (d[j]) s = s ^ pos;
                j++;
            end
        end
        for (int k = 0; k < p; k++) c[1 << k] = ((s >> k) & 1) != 0;
        c[0] = ^c[127:1];
        return c;
    endfunction

    function automatic logic [63:0] extract(input logic [127:0] c, input int dw);
        int cw = dw + calc_p(dw) + 1;
        int j = 0;
        logic [63:0] d = '0;
        for (int pos = 1; pos < cw; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[j] = c[pos];
                j++;
            end
        end
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one word into the main instance and wait (bounded) for its result.
    task automatic applyStimulus(input logic [7:0] code, input logic corr, output int lat);
        a_in_code  = code;
        a_cfg      = corr;
        a_in_valid = 1'b1;
        lat = 0;
        do begin
            tick();
            a_in_valid = 1'b0;
            lat++;
        end while (!a_out_valid && lat < 10);
    endtask

    task automatic sendWide(input int which, input logic [127:0] code, output int lat);
        if (which == 8) begin
            b_in_code  = code[12:0];
            b_in_valid = 1'b1;
        end else begin
            c_in_code  = code[38:0];
            c_in_valid = 1'b1;
        end
        lat = 0;
        do begin
            tick();
            b_in_valid = 1'b0;
            c_in_valid = 1'b0;
            lat++;
        end while (!((which == 8) ? b_out_valid : c_out_valid) && lat < 10);
    endtask

    // Random word with 0, 1 or 2 injected bit errors; expectation follows from the count.
    task automatic newWord();
        logic [7:0] clean;
        logic [7:0] err;
        logic [3:0] d;
        int nerr;
        int p1;
        int p2;
        d     = 4'($urandom_range(0, 15));
        clean = 8'(encode({60'b0, d}, 4));
        nerr  = $urandom_range(0, 2);
        p1    = $urandom_range(0, 7);
        p2    = (p1 + $urandom_range(1, 7)) % 8;
        err   = '0;
        if (nerr >= 1) err[p1] = 1'b1;
        if (nerr == 2) err[p2] = 1'b1;
        a_in_code = clean ^ err;
        a_cfg     = 1'($urandom_range(0, 1));
        pend.sec  = (nerr == 1);
        pend.ded  = (nerr == 2);
        pend.code = (nerr == 1 && a_cfg) ? clean : a_in_code;
        pend.data = 4'(extract({120'b0, pend.code}, 4));
    endtask

    initial begin
        int lat;
        int sent;
        int rcvd;
        int cyc;
        int exp_sec;
        int exp_ded;
        logic acc;
        logic held_v;
        logic [7:0] held_code;
        logic [3:0] held_data;
        logic held_sec;
        logic held_ded;
        logic [127:0] wclean;
        logic [127:0] wraw;
        logic [63:0] wdata;

        reset = 1'b0;
        a_in_valid = 0; a_cfg = 1; a_clr = 0; a_out_ready = 1; a_in_code = '0;
        s_in_valid = 0; s_cfg = 1; s_clr = 0; s_out_ready = 1; s_in_code = '0;
        b_in_valid = 0; b_cfg = 1; b_clr = 0; b_out_ready = 1; b_in_code = '0;
        c_in_valid = 0; c_cfg = 1; c_clr = 0; c_out_ready = 1; c_in_code = '0;

        #12;
        checkOutput("rst_out_valid", a_out_valid, 0);
        checkOutput("rst_out_data", a_out_data, 0);
        checkOutput("rst_out_code", a_out_code, 0);
        checkOutput("rst_flags", {a_sec, a_ded}, 0);
        checkOutput("rst_cnts", {a_cnt_sec, a_cnt_ded}, 0);
        reset = 1'b1;
        tick();
        checkOutput("rst_in_ready", a_in_ready, 1);

        // Directed words on the 4-bit instance
        applyStimulus(8'hAA, 1'b1, lat);
        checkOutput("clean_latency", lat, 2);
        checkOutput("clean_valid", a_out_valid, 1);
        checkOutput("clean_data", a_out_data, 4'hB);
        checkOutput("clean_code", a_out_code, 8'hAA);
        checkOutput("clean_flags", {a_sec, a_ded}, 2'b00);
        tick();
        checkOutput("clean_drained", a_out_valid, 0);
        checkOutput("clean_cnt_sec", a_cnt_sec, 0);

        applyStimulus(8'h8A, 1'b1, lat);
        checkOutput("sec5_code", a_out_code, 8'hAA);
        checkOutput("sec5_data", a_out_data, 4'hB);
        checkOutput("sec5_flags", {a_sec, a_ded}, 2'b10);
        tick();
        checkOutput("sec5_cnt_sec", a_cnt_sec, 1);

        applyStimulus(8'h8A, 1'b0, lat);
        checkOutput("detect_code", a_out_code, 8'h8A);
        checkOutput("detect_data", a_out_data, 4'h9);
        checkOutput("detect_flags", {a_sec, a_ded}, 2'b10);
        tick();
        checkOutput("detect_cnt_sec", a_cnt_sec, 2);

        applyStimulus(8'hAB, 1'b1, lat);
        checkOutput("sec0_code", a_out_code, 8'hAA);
        checkOutput("sec0_data", a_out_data, 4'hB);
        checkOutput("sec0_flags", {a_sec, a_ded}, 2'b10);
        tick();
        checkOutput("sec0_cnt_sec", a_cnt_sec, 3);

        applyStimulus(8'hE8, 1'b1, lat);
        checkOutput("ded_code", a_out_code, 8'hE8);
        checkOutput("ded_data", a_out_data, 4'hF);
        checkOutput("ded_flags", {a_sec, a_ded}, 2'b01);
        tick();
        checkOutput("ded_cnt_ded", a_cnt_ded, 1);

        // Random stream with pseudo-random backpressure
        sent = 0; rcvd = 0; cyc = 0; exp_sec = 3; exp_ded = 1; held_v = 1'b0;
        newWord();
        while ((sent < 20 || rcvd < 20) && cyc < 400) begin
            a_in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
            a_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (held_v) begin
                checkOutput("stall_valid", a_out_valid, 1);
                checkOutput("stall_payload", {a_out_code, a_out_data, a_sec, a_ded},
                            {held_code, held_data, held_sec, held_ded});
            end
            if (a_out_valid) begin
                if (a_out_ready) begin
                    checkOutput("stream_no_dup", q.size() != 0, 1);
                    if (q.size() != 0) begin
                        got = q.pop_front();
                        checkOutput("stream_code", a_out_code, got.code);
                        checkOutput("stream_data", a_out_data, got.data);
                        checkOutput("stream_flags", {a_sec, a_ded}, {got.sec, got.ded});
                        if (got.sec) exp_sec++;
                        if (got.ded) exp_ded++;
                    end
                    rcvd++;
                    held_v = 1'b0;
                end else begin
                    held_v    = 1'b1;
                    held_code = a_out_code;
                    held_data = a_out_data;
                    held_sec  = a_sec;
                    held_ded  = a_ded;
                end
            end
            acc = a_in_valid && a_in_ready;
            if (acc) begin
                q.push_back(pend);
                sent++;
            end
            tick();
            cyc++;
            if (acc) newWord();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        checkOutput("stream_sent", sent, 20);
        checkOutput("stream_rcvd", rcvd, 20);
        checkOutput("stream_queue_empty", q.size(), 0);
        checkOutput("stream_cnt_sec", a_cnt_sec, exp_sec);
        checkOutput("stream_cnt_ded", a_cnt_ded, exp_ded);

        // Asynchronous reset with a stalled pipeline full of words
        a_out_ready = 1'b0;
        a_in_code   = 8'hAA;
        a_in_valid  = 1'b1;
        tick();
        tick();
        tick();
        a_in_valid = 1'b0;
        checkOutput("pre_reset_valid", a_out_valid, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst_valid", a_out_valid, 0);
        checkOutput("midrst_payload", {a_out_code, a_out_data, a_sec, a_ded}, 0);
        checkOutput("midrst_cnts", {a_cnt_sec, a_cnt_ded}, 0);
        #1 reset = 1'b1;
        tick();
        a_out_ready = 1'b1;
        tick();
        checkOutput("postrst_in_ready", a_in_ready, 1);
        checkOutput("postrst_no_stale", a_out_valid, 0);

        // Saturation and clear-priority on the CNT_W=2 instance
        s_in_code  = 8'h8A;
        s_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        s_in_valid = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("sat_cnt_sec", s_cnt_sec, 3);
        checkOutput("sat_cnt_ded", s_cnt_ded, 0);
        s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        tick();
        checkOutput("clr_word_ready", {s_out_valid, s_sec}, 2'b11);
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        checkOutput("clr_wins_cnt_sec", s_cnt_sec, 0);
        checkOutput("clr_word_taken", s_out_valid, 0);

        // DATA_W=8: clean, single error, out-of-range syndrome
        wdata  = 64'($urandom_range(0, 255));
        wclean = encode(wdata, 8);
        sendWide(8, wclean, lat);
        checkOutput("w8_clean_latency", lat, 2);
        checkOutput("w8_clean_data", b_out_data, wdata[7:0]);
        checkOutput("w8_clean_code", b_out_code, wclean[12:0]);
        checkOutput("w8_clean_flags", {b_sec, b_ded}, 2'b00);
        tick();
        wraw = wclean ^ (128'b1 << 9);
        sendWide(8, wraw, lat);
        checkOutput("w8_sec_code", b_out_code, wclean[12:0]);
        checkOutput("w8_sec_flags", {b_sec, b_ded}, 2'b10);
        tick();
        wraw = wclean ^ (128'b1 << 12) ^ (128'b1 << 2) ^ (128'b1 << 1);
        sendWide(8, wraw, lat);
        checkOutput("w8_oor_flags", {b_sec, b_ded}, 2'b01);
        checkOutput("w8_oor_code", b_out_code, wraw[12:0]);
        checkOutput("w8_oor_data", b_out_data, extract(wraw, 8));
        tick();

        // DATA_W=32: clean and out-of-range syndrome
        wdata  = {32'b0, $urandom};
        wclean = encode(wdata, 32);
        sendWide(32, wclean, lat);
        checkOutput("w32_clean_latency", lat, 2);
        checkOutput("w32_clean_data", c_out_data, wdata[31:0]);
        checkOutput("w32_clean_code", c_out_code, wclean[38:0]);
        checkOutput("w32_clean_flags", {c_sec, c_ded}, 2'b00);
        tick();
        wraw = wclean ^ (128'b1 << 32) ^ (128'b1 << 16) ^ (128'b1 << 8);
        sendWide(32, wraw, lat);
        checkOutput("w32_oor_flags", {c_sec, c_ded}, 2'b01);
        checkOutput("w32_oor_code", c_out_code, wraw[38:0]);
        tick();

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/secded_pipe_decoder.md
Name: secded_pipe_decoder

Overview:
- Parametrised, pipelined extended-Hamming SECDED decoder.
- Generalises the fixed 4-bit Hamming(7,4)+overall-parity decoder to any data width.
- Adds a valid/ready stream interface with backpressure, a detect-only mode, and saturating error-statistics counters.
- Sits on the receive side of the ECC-protected link, downstream of the channel/error-injection stage and upstream of the consumer.

Parameters:
DATA_W, 4, data bits per word (1..64); parity count P derived as smallest P with 2^P >= DATA_W+P+1; codeword width CW = DATA_W+P+1 (CW=8 at default)
CNT_W, 16, width of each error-statistics counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
in_valid  input  1  codeword present on in_code
in_ready  output  1  block can accept in_code this cycle
in_code  input  CW  received codeword
cfg_correct  input  1  1 = correct single errors, 0 = detect-only
cnt_clear  input  1  synchronous clear of both counters
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  DATA_W  decoded data
out_code  output  CW  corrected (or raw) codeword
out_sec  output  1  single error detected (corrected if cfg_correct)
out_ded  output  1  uncorrectable error detected
cnt_sec  output  CNT_W  saturating count of SEC results delivered
cnt_ded  output  CNT_W  saturating count of DED results delivered

Behaviour:
- Codeword layout:
  - bit 0 = overall even parity over bits CW-1..1.
  - Bits 1..CW-1 = Hamming positions 1..CW-1.
  - Check bits sit at power-of-two positions.
  - Data bits fill the remaining positions in ascending order, LSB first. At DATA_W=4: d[0..3] at positions 3,5,6,7.
- Check bit at position 2^k = XOR of all positions with bit k set.
- Syndrome S (P bits) = XOR of indices of all set bits in positions 1..CW-1. Overall check G = XOR of all CW bits.
- Classification:
  - S=0, G=0: clean.
  - S=0, G=1: SEC, error in bit 0.
  - S!=0, G=1, S<=CW-1: SEC, error at position S.
  - S!=0, G=1, S>CW-1: DED (out-of-range syndrome).
  - S!=0, G=0: DED.
- out_sec and out_ded are never both 1.
- Correction:
  - SEC with cfg_correct=1: out_code = in_code with the indicated bit flipped.
  - Otherwise out_code = in_code.
  - out_data is always extracted from out_code.
- cfg_correct is sampled with the word at input acceptance and travels with it.
- Pipeline:
  - Two register stages. Stage 1 holds codeword, S, G and the cfg bit. Stage 2 holds corrected outputs and flags.
  - Latency is exactly 2 cycles from input handshake to out_valid when out_ready is held 1.
  - Throughput is 1 word/cycle.
- Handshake:
  - Input transfer when in_valid&&in_ready. Output transfer when out_valid&&out_ready.
  - Stage 2 loads when empty or transferring. Stage 1 loads when empty or moving to stage 2.
  - in_ready = !s1_v || !s2_v || out_ready.
  - Output payload is held stable while out_valid=1 and out_ready=0. No word is lost or duplicated under any stall pattern.
  - out_valid does not depend combinationally on out_ready.
- Counters:
  - cnt_sec increments on an output transfer with out_sec=1; cnt_ded increments on an output transfer with out_ded=1.
  - Both saturate at 2^CNT_W-1.
  - cnt_clear forces both to 0 next cycle and wins over a simultaneous increment.
- Reset (asynchronous, any time including mid-stream):
  - Both stages are invalidated and in-flight words are dropped.
  - out_valid=0, out_data=0, out_code=0, out_sec=0, out_ded=0, cnt_sec=0, cnt_ded=0.
  - in_ready=1 once reset deasserts.

Test Plan:
- DATA_W=4, cfg_correct=1, in_code=8'hAA (data 4'hB), out_ready=1 -> 2 cycles later out_valid=1, out_data=4'hB, out_code=8'hAA, sec=0, ded=0.
- in_code=8'h8A (bit 5 flipped) -> out_code=8'hAA, out_data=4'hB, out_sec=1, cnt_sec=1.
  - Same word with cfg_correct=0 -> out_code=8'h8A, out_data=4'h9, out_sec=1.
- in_code=8'hAB (bit 0 flipped) -> out_sec=1, out_code=8'hAA, out_data=4'hB.
- in_code=8'hE8 (bits 1,6 flipped) -> out_ded=1, out_sec=0, out_code=8'hE8, out_data=4'hF, cnt_ded=1.
- Stream 20 random words with injected 0/1/2-bit errors while out_ready toggles pseudo-randomly -> outputs match the scoreboard in order, no drops or duplicates, payload stable during stalls.
  - Assert reset=0 mid-stream -> all outputs and counters 0 immediately.
- CNT_W=2: deliver 5 SEC words -> cnt_sec saturates at 3.
  - cnt_clear asserted together with a SEC transfer -> cnt_sec=0.
  - Repeat clean-word check at DATA_W=8 (CW=13) and DATA_W=32 (CW=39), including an out-of-range-syndrome case flagged DED.
